ysyx_22040125_exec_seq: RTL and testbench
=========================================

Name: ysyx_22040125_exec_seq

Overview:
Multi-cycle execution sequencer for the RV64 core. It is the successor to the single-cycle datapath top: fetch and data memory sit behind valid/ready request plus response-valid buses with arbitrary wait states. The sequencer owns PC, the instruction latch, writeback timing, retire counting and halt (ebreak/illegal/bus timeout). Decoder, ALU, regfile and load extension stay external and combinational around it.

Parameters:
XLEN, 64, datapath and PC width
ADDR_W, 32, bus address width (PC/address truncated to low ADDR_W bits)
RESET_PC, 64'h8000_0000, PC after reset
TIMEOUT_CYC, 255, max cycles per bus transaction before fault halt; 0 disables

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req_valid  out  1  fetch request valid
if_req_ready  in  1  fetch request accepted
if_addr  out  ADDR_W  fetch address = pc[ADDR_W-1:0]
if_rsp_valid  in  1  fetch data valid
if_rsp_data  in  32  fetched instruction
inst  out  32  latched instruction to decoder
dec_reg_wen  in  1  instruction writes rd
dec_is_load  in  1  load
dec_is_store  in  1  store
dec_ebreak  in  1  ebreak
dec_illegal  in  1  undecodable instruction
ex_redirect  in  1  jump/taken branch
ex_next_pc  in  XLEN  redirect target
ex_result  in  XLEN  ALU result
ex_mem_addr  in  ADDR_W  load/store address
ex_wdata  in  XLEN  store data
d_req_valid  out  1  data request valid
d_req_ready  in  1  data request accepted
d_req_we  out  1  1 = store
d_addr  out  ADDR_W  data address
d_wdata  out  XLEN  store data
d_rsp_valid  in  1  load data valid / store ack
d_rsp_data  in  XLEN  raw load data
pc  out  XLEN  current PC
wb_en  out  1  regfile write strobe (one cycle)
wb_data  out  XLEN  load ? latched d_rsp_data : latched ex_result
retire  out  1  one-cycle pulse per retired instruction
instret  out  64  retired-instruction count
halted  out  1  sticky halt
halt_cause  out  2  00 none, 01 ebreak, 10 illegal, 11 bus timeout

Behaviour:
- Reset (async, rst=0): state IF_REQ, pc=RESET_PC, inst=0, instret=0, halt_cause=00. All other outputs 0; if_req_valid is combinational, so it reads 1 once reset releases.
- States: IF_REQ -> IF_WAIT -> EXEC -> {MEM_REQ -> MEM_WAIT ->} WB -> IF_REQ; any -> HALT.
- IF_REQ: if_req_valid=1, if_addr stable until if_req_ready; on handshake -> IF_WAIT.
- IF_WAIT: if_rsp_valid latches inst and -> EXEC. A response in the same cycle as the request handshake is ignored.
- EXEC (1 cycle): latch ex_result, ex_next_pc, ex_redirect, dec_reg_wen, dec_is_load, ex_mem_addr, ex_wdata.
  - Priority: dec_illegal -> HALT cause 10, no retire.
  - Else dec_ebreak -> HALT cause 01 with retire pulse, instret+1, pc unchanged.
  - Else load/store -> MEM_REQ.
  - Else -> WB.
- MEM_REQ: d_req_valid=1 with d_req_we, d_addr, d_wdata held stable until d_req_ready -> MEM_WAIT.
- MEM_WAIT: d_rsp_valid latches d_rsp_data (loads) -> WB. Stores wait for d_rsp_valid as ack.
- WB (1 cycle): wb_en = latched reg_wen and not store; retire=1; instret+1; pc <= redirect ? ex_next_pc : pc+4 (mod 2^XLEN); -> IF_REQ.
- Minimum latency with zero-wait bus: ALU op 4 cycles (IF_REQ, IF_WAIT, EXEC, WB); load/store 6 cycles.
- Timeout: per-transaction counter cleared on entering IF_REQ/MEM_REQ. It increments each cycle in REQ/WAIT without completion. When it reaches TIMEOUT_CYC -> HALT cause 11, and the request is dropped.
- HALT: no requests, wb_en=0, retire=0, halted=1, and pc, inst, instret and halt_cause frozen until reset.
- A bus input asserted in an unrelated state is ignored.
- instret wraps at 2^64.
- Reset mid-transaction abandons it; the bus must tolerate the dropped request.

Decomposition:
- Package ysyx_22040125_seq_pkg holds the state enum, halt-cause codes (HC_NONE, HC_EBREAK, HC_ILLEGAL, HC_TIMEOUT), INST_W=32 and INST_BYTES=4.
- One sub-module, ysyx_22040125_wait_timer: clear, count-enable and expire for the timeout, with TIMEOUT_CYC=0 never expiring.

Test Plan:
- Zero-wait bus, addi at 0x8000_0000 -> wb_en and retire in cycle 4 after reset release; pc=0x8000_0004; instret=1.
- Fetch with if_req_ready low 3 cycles and response 2 cycles later -> if_addr stable throughout; inst latched; no retire before response.
- jal redirect to 0x8000_0100 -> next if_addr=0x8000_0100.
- Load, d_rsp_data=0x1234 after 5-cycle wait -> wb_data=0x1234 with one wb_en pulse.
- Store -> d_req_we=1, wb_en=0, retire on ack.
- ebreak -> halted=1, halt_cause=01, instret+1, no further if_req_valid.
- Illegal instruction -> halt_cause=10, instret unchanged.
- TIMEOUT_CYC=8 with if_req_ready stuck 0 -> halt_cause=11 after 8 cycles.
- TIMEOUT_CYC=0 with if_req_ready stuck 0 -> never halts.
- rst low during MEM_WAIT -> pc=RESET_PC and instret=0 immediately; fetch restarts after release.

Source files
------------

// File: rtl/ysyx_22040125_seq_pkg.sv
// Shared types and constants for the multi-cycle execution sequencer.
// State encoding, halt-cause codes and instruction geometry live here.
package ysyx_22040125_seq_pkg;

    localparam int INST_W     = 32;
    localparam int INST_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IF_REQ   = 3'd0,
        ST_IF_WAIT  = 3'd1,
        ST_EXEC     = 3'd2,
        ST_MEM_REQ  = 3'd3,
        ST_MEM_WAIT = 3'd4,
        ST_WB       = 3'd5,
        ST_HALT     = 3'd6
    } seq_state_e;

    typedef logic [1:0] halt_cause_t;

    localparam halt_cause_t HC_NONE    = 2'b00;
    localparam halt_cause_t HC_EBREAK  = 2'b01;
    localparam halt_cause_t HC_ILLEGAL = 2'b10;
    localparam halt_cause_t HC_TIMEOUT = 2'b11;

endpackage

// File: rtl/ysyx_22040125_wait_timer.sv
// Per-transaction bus watchdog: a down-counter loaded with TIMEOUT_CYC on clear.
// expire fires on the enabled cycle that would exhaust the budget; TIMEOUT_CYC=0 never expires.
module ysyx_22040125_wait_timer #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] remain_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remain_q <= LOAD_VAL;
        end else if (clear) begin
            remain_q <= LOAD_VAL;
        end else if (count_en && (remain_q != '0)) begin
            remain_q <= remain_q - ONE;
        end
    end

    // Terminal-count compare; the disabled case has no terminal count at all.
    assign expire = (TIMEOUT_CYC != 0) && count_en && (remain_q == ONE);

endmodule

// File: rtl/ysyx_22040125_exec_seq.sv
// Multi-cycle execution sequencer: owns PC, instruction latch, writeback timing,
// retire counting and halt around an external combinational decode/ALU/regfile.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IF_REQ      | fetch request presented, waiting for if_req_ready
// IF_WAIT     | fetch accepted, waiting for if_rsp_valid
// EXEC        | decode/ALU results sampled; pick halt, memory or writeback
// MEM_REQ     | data request presented, waiting for d_req_ready
// MEM_WAIT    | data accepted, waiting for load data / store ack
// WB          | regfile write strobe, retire, PC advance
// HALT        | sticky stop until reset
module ysyx_22040125_exec_seq
    import ysyx_22040125_seq_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter int              ADDR_W      = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(64'h8000_0000),
    parameter int unsigned     TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    output logic              if_req_valid,
    input  logic              if_req_ready,
    output logic [ADDR_W-1:0] if_addr,
    input  logic              if_rsp_valid,
    input  logic [INST_W-1:0] if_rsp_data,
    output logic [INST_W-1:0] inst,
    input  logic              dec_reg_wen,
    input  logic              dec_is_load,
    input  logic              dec_is_store,
    input  logic              dec_ebreak,
    input  logic              dec_illegal,
    input  logic              ex_redirect,
    input  logic [XLEN-1:0]   ex_next_pc,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [XLEN-1:0]   ex_wdata,
    output logic              d_req_valid,
    input  logic              d_req_ready,
    output logic              d_req_we,
    output logic [ADDR_W-1:0] d_addr,
    output logic [XLEN-1:0]   d_wdata,
    input  logic              d_rsp_valid,
    input  logic [XLEN-1:0]   d_rsp_data,
    output logic [XLEN-1:0]   pc,
    output logic              wb_en,
    output logic [XLEN-1:0]   wb_data,
    output logic              retire,
    output logic [63:0]       instret,
    output logic              halted,
    output logic [1:0]        halt_cause
);

    seq_state_e state_q, state_d;

    logic [XLEN-1:0]   pc_q;
    logic [INST_W-1:0] inst_q;
    logic [63:0]       instret_q;
    halt_cause_t       halt_cause_q;

    logic [XLEN-1:0]   result_q;
    logic [XLEN-1:0]   next_pc_q;
    logic              redirect_q;
    logic              reg_wen_q;
    logic              is_load_q;
    logic              is_store_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   load_q;

    logic              fsm_if_req;
    logic              halt_set;
    halt_cause_t       halt_code;

    logic              tmr_clear;
    logic              tmr_en;
    logic              tmr_expire;

    // Counting is kept outside the FSM block so expire never feeds back into its own enable.
    assign tmr_en = ((state_q == ST_IF_REQ)   && !if_req_ready) ||
                    ((state_q == ST_IF_WAIT)  && !if_rsp_valid) ||
                    ((state_q == ST_MEM_REQ)  && !d_req_ready)  ||
                    ((state_q == ST_MEM_WAIT) && !d_rsp_valid);

    assign tmr_clear = (state_d != state_q) &&
                       ((state_d == ST_IF_REQ) || (state_d == ST_MEM_REQ));

    ysyx_22040125_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmr_clear),
        .count_en (tmr_en),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IF_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fsm_if_req  = 1'b0;
        d_req_valid = 1'b0;
        wb_en       = 1'b0;
        retire      = 1'b0;
        halt_set    = 1'b0;
        halt_code   = HC_NONE;

        case (state_q)
            ST_IF_REQ: begin
                fsm_if_req = 1'b1;
                if (if_req_ready) begin
                    state_d = ST_IF_WAIT;
                end else if (tmr_expire) begin
                    state_d   = ST_HALT;
                    halt_set  = 1'b1;
                    halt_code = HC_TIMEOUT;
                end
            end
            ST_IF_WAIT: begin
                if (if_rsp_valid) begin
                    state_d = ST_EXEC;
                end else if (tmr_expire) begin
                    state_d   = ST_HALT;
                    halt_set  = 1'b1;
                    halt_code = HC_TIMEOUT;
                end
            end
            ST_EXEC: begin
                if (dec_illegal) begin
                    state_d   = ST_HALT;
                    halt_set  = 1'b1;
                    halt_code = HC_ILLEGAL;
                end else if (dec_ebreak) begin
                    // ebreak completes architecturally, so it counts as retired.
                    state_d   = ST_HALT;
                    halt_set  = 1'b1;
                    halt_code = HC_EBREAK;
                    retire    = 1'b1;
                end else if (dec_is_load || dec_is_store) begin
                    state_d = ST_MEM_REQ;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM_REQ: begin
                d_req_valid = 1'b1;
                if (d_req_ready) begin
                    state_d = ST_MEM_WAIT;
                end else if (tmr_expire) begin
                    state_d   = ST_HALT;
                    halt_set  = 1'b1;
                    halt_code = HC_TIMEOUT;
                end
            end
            ST_MEM_WAIT: begin
                if (d_rsp_valid) begin
                    state_d = ST_WB;
                end else if (tmr_expire) begin
                    state_d   = ST_HALT;
                    halt_set  = 1'b1;
                    halt_code = HC_TIMEOUT;
                end
            end
            ST_WB: begin
                wb_en   = reg_wen_q && !is_store_q;
                retire  = 1'b1;
                state_d = ST_IF_REQ;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IF_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            instret_q    <= '0;
            halt_cause_q <= HC_NONE;
            result_q     <= '0;
            next_pc_q    <= '0;
            redirect_q   <= 1'b0;
            reg_wen_q    <= 1'b0;
            is_load_q    <= 1'b0;
            is_store_q   <= 1'b0;
            mem_addr_q   <= '0;
            wdata_q      <= '0;
            load_q       <= '0;
        end else begin
            if ((state_q == ST_IF_WAIT) && if_rsp_valid) begin
                inst_q <= if_rsp_data;
            end
            if (state_q == ST_EXEC) begin
                result_q   <= ex_result;
                next_pc_q  <= ex_next_pc;
                redirect_q <= ex_redirect;
                reg_wen_q  <= dec_reg_wen;
                is_load_q  <= dec_is_load;
                is_store_q <= dec_is_store;
                mem_addr_q <= ex_mem_addr;
                wdata_q    <= ex_wdata;
            end
            if ((state_q == ST_MEM_WAIT) && d_rsp_valid && is_load_q) begin
                load_q <= d_rsp_data;
            end
            if (state_q == ST_WB) begin
                pc_q <= redirect_q ? next_pc_q : (pc_q + XLEN'(INST_BYTES));
            end
            if (retire) begin
                instret_q <= instret_q + 64'd1;
            end
            if (halt_set) begin
                halt_cause_q <= halt_code;
            end
        end
    end

    // The fetch request is combinational from state; hold it off while reset is asserted.
    assign if_req_valid = fsm_if_req && rst;
    assign if_addr      = pc_q[ADDR_W-1:0];
    assign inst         = inst_q;
    assign d_req_we     = is_store_q;
    assign d_addr       = mem_addr_q;
    assign d_wdata      = wdata_q;
    assign pc           = pc_q;
    assign wb_data      = is_load_q ? load_q : result_q;
    assign instret      = instret_q;
    assign halted       = (state_q == ST_HALT);
    assign halt_cause   = halt_cause_q;

endmodule

// File: tb/tb_ysyx_22040125_exec_seq.sv
// Scoreboard bench for the execution sequencer: directed instructions push expected
// fetch addresses and retire records; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_ysyx_22040125_exec_seq;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic z_rst = 1'b0;
    always #5 clk = ~clk;

    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0] if_addr, if_rsp_data, inst;
    logic        dec_reg_wen, dec_is_load, dec_is_store, dec_ebreak, dec_illegal, ex_redirect;
    logic [63:0] ex_next_pc, ex_result, ex_wdata;
    logic [31:0] ex_mem_addr;
    logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
    logic [31:0] d_addr;
    logic [63:0] d_wdata, d_rsp_data;
    logic [63:0] pc, wb_data, instret;
    logic        wb_en, retire, halted;
    logic [1:0]  halt_cause;

    logic        z_if_req_valid, z_d_req_valid, z_d_req_we, z_wb_en, z_retire, z_halted;
    logic [31:0] z_if_addr, z_inst, z_d_addr;
    logic [63:0] z_d_wdata, z_pc, z_wb_data, z_instret;
    logic [1:0]  z_halt_cause;

    ysyx_22040125_exec_seq #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .inst(inst),
        .dec_reg_wen(dec_reg_wen), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
        .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal), .ex_redirect(ex_redirect),
        .ex_next_pc(ex_next_pc), .ex_result(ex_result), .ex_mem_addr(ex_mem_addr),
        .ex_wdata(ex_wdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .pc(pc), .wb_en(wb_en), .wb_data(wb_data), .retire(retire), .instret(instret),
        .halted(halted), .halt_cause(halt_cause)
    );

    ysyx_22040125_exec_seq #(.TIMEOUT_CYC(0)) dut_notmo (
        .clk(clk), .rst(z_rst),
        .if_req_valid(z_if_req_valid), .if_req_ready(1'b0), .if_addr(z_if_addr),
        .if_rsp_valid(1'b0), .if_rsp_data(32'h0), .inst(z_inst),
        .dec_reg_wen(1'b0), .dec_is_load(1'b0), .dec_is_store(1'b0),
        .dec_ebreak(1'b0), .dec_illegal(1'b0), .ex_redirect(1'b0),
        .ex_next_pc(64'h0), .ex_result(64'h0), .ex_mem_addr(32'h0), .ex_wdata(64'h0),
        .d_req_valid(z_d_req_valid), .d_req_ready(1'b0), .d_req_we(z_d_req_we),
        .d_addr(z_d_addr), .d_wdata(z_d_wdata), .d_rsp_valid(1'b0), .d_rsp_data(64'h0),
        .pc(z_pc), .wb_en(z_wb_en), .wb_data(z_wb_data), .retire(z_retire),
        .instret(z_instret), .halted(z_halted), .halt_cause(z_halt_cause)
    );

    typedef struct packed {
        logic        wb_en;
        logic [63:0] wb_data;
        logic [63:0] pc;
        logic [63:0] instret;
    } ret_t;

    ret_t        ret_q[$];
    logic [31:0] fetch_q[$];
    ret_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          first_ret_cyc = -1;
    logic        z_halt_seen = 1'b0;
    logic [63:0] m_pc = RESET_PC;
    logic [63:0] m_instret = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (z_halted) z_halt_seen = 1'b1;
        if (rst) begin
            if (if_req_valid && (fetch_q.size() != 0)) begin
                chk("if_addr", 64'(if_addr), 64'(fetch_q[0]));
                if (if_req_ready) void'(fetch_q.pop_front());
            end
            if (wb_en || retire) chk("wb_en_implies_retire", 64'(wb_en & ~retire), 64'd0);
            if (retire) begin
                if (first_ret_cyc < 0) first_ret_cyc = cyc + 1;
                if (ret_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_retire: got retire at pc %h expected none", pc);
                end else begin
                    mon_e = ret_q.pop_front();
                    chk("ret_wb_en", 64'(wb_en), 64'(mon_e.wb_en));
                    chk("ret_pc", pc, mon_e.pc);
                    chk("ret_instret", instret, mon_e.instret);
                    if (mon_e.wb_en) chk("ret_wb_data", wb_data, mon_e.wb_data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic wen, input logic ld, input logic st, input logic eb,
                           input logic ill, input logic redir, input logic [63:0] npc,
                           input logic [63:0] res, input logic [31:0] maddr,
                           input logic [63:0] wd);
        dec_reg_wen = wen; dec_is_load = ld; dec_is_store = st; dec_ebreak = eb;
        dec_illegal = ill; ex_redirect = redir; ex_next_pc = npc; ex_result = res;
        ex_mem_addr = maddr; ex_wdata = wd;
    endtask

    task automatic chk_dreq();
        chk("d_req_valid", 64'(d_req_valid), 64'd1);
        chk("d_addr", 64'(d_addr), 64'(ex_mem_addr));
        chk("d_req_we", 64'(d_req_we), 64'(dec_is_store));
        if (dec_is_store) chk("d_wdata", d_wdata, ex_wdata);
    endtask

    // Runs one instruction from IF_REQ; returns in IF_REQ, HALT, or (abort) MEM_WAIT.
    task automatic do_inst(input logic [31:0] iw, input int f_rdy, input int f_rsp,
                           input int m_rdy, input int m_rsp, input logic [63:0] ld_data,
                           input logic early_rsp, input logic abort);
        logic mem;
        ret_t e;
        mem = dec_is_load | dec_is_store;
        fetch_q.push_back(m_pc[31:0]);
        if (!dec_illegal && !abort) begin
            e.wb_en   = dec_reg_wen & ~dec_is_store & ~dec_ebreak;
            e.wb_data = dec_is_load ? ld_data : ex_result;
            e.pc      = m_pc;
            e.instret = m_instret;
            ret_q.push_back(e);
            m_instret = m_instret + 64'd1;
            if (!dec_ebreak) m_pc = ex_redirect ? ex_next_pc : m_pc + 64'd4;
        end
        if_req_ready = 1'b0;
        for (int i = 0; i < f_rdy; i++) begin
            if_rsp_valid = early_rsp; if_rsp_data = 32'hDEAD_BEEF;
            step();
            chk("if_req_held", 64'(if_req_valid), 64'd1);
        end
        if_req_ready = 1'b1; if_rsp_valid = early_rsp; if_rsp_data = 32'hDEAD_BEEF;
        step();
        if_req_ready = 1'b0; if_rsp_valid = 1'b0;
        for (int i = 0; i < f_rsp; i++) begin
            chk("no_retire_in_fetch", 64'(retire), 64'd0);
            step();
        end
        if_rsp_valid = 1'b1; if_rsp_data = iw;
        step();
        if_rsp_valid = 1'b0; if_rsp_data = 32'h0;
        chk("inst_latched", 64'(inst), 64'(iw));
        if (dec_illegal || dec_ebreak) begin
            step();
            return;
        end
        if (mem) begin
            step();
            for (int i = 0; i < m_rdy; i++) begin
                chk_dreq();
                step();
            end
            chk_dreq();
            d_req_ready = 1'b1;
            step();
            d_req_ready = 1'b0;
            if (abort) begin
                step();
                return;
            end
            for (int i = 0; i < m_rsp; i++) step();
            d_rsp_valid = 1'b1; d_rsp_data = ld_data;
            step();
            d_rsp_valid = 1'b0; d_rsp_data = 64'h0;
        end else begin
            step();
        end
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_pc", pc, RESET_PC);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_halt_cause", 64'(halt_cause), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_if_req_valid", 64'(if_req_valid), 64'd0);
        chk("rst_d_req_valid", 64'(d_req_valid), 64'd0);
        chk("rst_retire", 64'(retire), 64'd0);
        fetch_q.delete();
        ret_q.delete();
        m_pc = RESET_PC;
        m_instret = 64'd0;
        if_req_ready = 1'b0; if_rsp_valid = 1'b0; if_rsp_data = 32'h0;
        d_req_ready = 1'b0; d_rsp_valid = 1'b0; d_rsp_data = 64'h0;
        set_dec(0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 32'h0, 64'h0);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("fetch_after_release", 64'(if_req_valid), 64'd1);
    endtask

    initial begin
        if_req_ready = 1'b0; if_rsp_valid = 1'b0; if_rsp_data = 32'h0;
        d_req_ready = 1'b0; d_rsp_valid = 1'b0; d_rsp_data = 64'h0;
        set_dec(0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 32'h0, 64'h0);
        step();
        step();
        first_ret_cyc = -1;
        do_reset();
        z_rst = 1'b1;

        // addi, zero-wait bus
        set_dec(1, 0, 0, 0, 0, 0, 64'h0, 64'h2A, 32'h0, 64'h0);
        do_inst(32'h02A0_0093, 0, 0, 0, 0, 64'h0, 1'b0, 1'b0);
        chk("first_retire_cycle", 64'(first_ret_cyc), 64'd4);
        chk("pc_after_addi", pc, 64'h8000_0004);
        chk("instret_after_addi", instret, 64'd1);

        // fetch with ready low 3 cycles, response 2 cycles later, stray responses ignored
        set_dec(1, 0, 0, 0, 0, 0, 64'h0, 64'h5, 32'h0, 64'h0);
        do_inst(32'h0050_0093, 3, 2, 0, 0, 64'h0, 1'b1, 1'b0);
        chk("inst_held", 64'(inst), 64'h0050_0093);
        chk("pc_after_slow_fetch", pc, 64'h8000_0008);

        // jal to 0x8000_0100
        set_dec(1, 0, 0, 0, 0, 1, 64'h8000_0100, 64'h8000_000C, 32'h0, 64'h0);
        do_inst(32'h0F80_00EF, 0, 0, 0, 0, 64'h0, 1'b0, 1'b0);
        chk("pc_after_jal", pc, 64'h8000_0100);

        // load, 1-cycle ready stall, 5-cycle response wait
        set_dec(1, 1, 0, 0, 0, 0, 64'h0, 64'h8000_1000, 32'h8000_1000, 64'h0);
        do_inst(32'h0000_3503, 0, 0, 1, 5, 64'h1234, 1'b0, 1'b0);
        chk("pc_after_load", pc, 64'h8000_0104);

        // store with reg_wen set by decode: writeback must stay off
        set_dec(1, 0, 1, 0, 0, 0, 64'h0, 64'h8000_1008, 32'h8000_1008, 64'hCAFE_F00D_1234_5678);
        do_inst(32'h00A5_3423, 0, 0, 2, 1, 64'h0, 1'b0, 1'b0);
        chk("pc_after_store", pc, 64'h8000_0108);
        chk("instret_after_store", instret, 64'd5);

        // ebreak
        set_dec(0, 0, 0, 1, 0, 0, 64'h0, 64'h0, 32'h0, 64'h0);
        do_inst(32'h0010_0073, 0, 0, 0, 0, 64'h0, 1'b0, 1'b0);
        chk("ebreak_halted", 64'(halted), 64'd1);
        chk("ebreak_cause", 64'(halt_cause), 64'd1);
        chk("ebreak_instret", instret, 64'd6);
        if_req_ready = 1'b1; d_req_ready = 1'b1; if_rsp_valid = 1'b1; d_rsp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("halt_no_fetch", 64'(if_req_valid), 64'd0);
            chk("halt_no_dreq", 64'(d_req_valid), 64'd0);
        end
        if_req_ready = 1'b0; d_req_ready = 1'b0; if_rsp_valid = 1'b0; d_rsp_valid = 1'b0;
        chk("halt_pc_frozen", pc, 64'h8000_0108);
        chk("halt_instret_frozen", instret, 64'd6);
        chk("halt_inst_frozen", 64'(inst), 64'h0010_0073);

        // illegal beats ebreak, no retire
        do_reset();
        set_dec(0, 0, 0, 1, 1, 0, 64'h0, 64'h0, 32'h0, 64'h0);
        do_inst(32'hFFFF_FFFF, 0, 0, 0, 0, 64'h0, 1'b0, 1'b0);
        chk("illegal_halted", 64'(halted), 64'd1);
        chk("illegal_cause", 64'(halt_cause), 64'd2);
        chk("illegal_instret", instret, 64'd0);

        // reset during MEM_WAIT
        do_reset();
        set_dec(1, 0, 0, 0, 0, 0, 64'h0, 64'h7, 32'h0, 64'h0);
        do_inst(32'h0070_0093, 0, 0, 0, 0, 64'h0, 1'b0, 1'b0);
        set_dec(1, 1, 0, 0, 0, 0, 64'h0, 64'h8000_2000, 32'h8000_2000, 64'h0);
        do_inst(32'h0000_3503, 0, 0, 0, 0, 64'h0, 1'b0, 1'b1);
        do_reset();
        set_dec(1, 0, 0, 0, 0, 0, 64'h0, 64'h99, 32'h0, 64'h0);
        do_inst(32'h0990_0093, 0, 0, 0, 0, 64'h0, 1'b0, 1'b0);
        chk("pc_after_restart", pc, 64'h8000_0004);

        // fetch timeout after 8 stalled cycles
        do_reset();
        fetch_q.push_back(m_pc[31:0]);
        if_req_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("timeout_not_yet", 64'(halted), 64'd0);
        end
        step();
        chk("timeout_halted", 64'(halted), 64'd1);
        chk("timeout_cause", 64'(halt_cause), 64'd3);
        chk("timeout_req_dropped", 64'(if_req_valid), 64'd0);

        // disabled watchdog instance has been stalled since the start
        for (int i = 0; i < 300; i++) step();
        chk("notmo_never_halted", 64'(z_halt_seen), 64'd0);
        chk("notmo_still_requesting", 64'(z_if_req_valid), 64'd1);
        chk("scoreboard_drained", 64'(ret_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
